// File: rtl/draw_scheduler.sv
// draw_scheduler: queues draw commands, launches one of two shape generators,
// and offsets, clips and forwards the pixels that generator produces.
module draw_scheduler #(
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int DEPTH  = 4
) (
    input  logic               _clock,
    input  logic               _reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_shape,
    input  logic signed [31:0] cmd_radius,
    input  logic signed [31:0] cmd_cx,
    input  logic signed [31:0] cmd_cy,
    output logic               gen0_start,
    output logic signed [31:0] gen0_radius,
    input  logic               gen0_valid,
    input  logic               gen0_done,
    input  logic signed [31:0] gen0_out0,
    input  logic signed [31:0] gen0_out1,
    output logic               gen1_start,
    output logic signed [31:0] gen1_radius,
    input  logic               gen1_valid,
    input  logic               gen1_done,
    input  logic signed [31:0] gen1_out0,
    input  logic signed [31:0] gen1_out1,
    output logic               _valid,
    output logic signed [31:0] _out0,
    output logic signed [31:0] _out1,
    output logic               _shape,
    output logic               cmd_done,
    output logic               busy,
    output logic [15:0]        clip_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, RUN = 2'd2;
    logic [1:0] state;
    logic [AW:0] count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic q_shape [DEPTH];
    logic signed [31:0] q_radius [DEPTH];
    logic signed [31:0] q_cx [DEPTH];
    logic signed [31:0] q_cy [DEPTH];
    logic act_shape;
    logic signed [31:0] act_radius, act_cx, act_cy, px, py;
    logic push, pop, pix, sel_done, in_bounds;
    always_comb begin
        cmd_ready   = count != (AW+1)'(DEPTH);
        push        = cmd_valid && cmd_ready;
        pop         = state == IDLE && count != '0;
        pix         = state == RUN && (act_shape ? gen1_valid : gen0_valid);
        sel_done    = state == RUN && (act_shape ? gen1_done : gen0_done);
        px          = act_cx + (act_shape ? gen1_out0 : gen0_out0);
        py          = act_cy + (act_shape ? gen1_out1 : gen0_out1);
        in_bounds   = px >= 0 && px < WIDTH && py >= 0 && py < HEIGHT;
        gen0_start  = state == LAUNCH && !act_shape;
        gen1_start  = state == LAUNCH && act_shape;
        gen0_radius = act_shape ? '0 : act_radius;
        gen1_radius = act_shape ? act_radius : '0;
        busy        = count != '0 || state != IDLE || cmd_done || _valid;
    end
    always_ff @(posedge _clock) begin
        if (push && _reset_n) begin
            q_shape[wr_ptr]  <= cmd_shape;
            q_radius[wr_ptr] <= cmd_radius;
            q_cx[wr_ptr]     <= cmd_cx;
            q_cy[wr_ptr]     <= cmd_cy;
        end
    end
    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            act_shape  <= 1'b0;
            act_radius <= '0;
            act_cx     <= '0;
            act_cy     <= '0;
            _valid     <= 1'b0;
            _out0      <= '0;
            _out1      <= '0;
            _shape     <= 1'b0;
            cmd_done   <= 1'b0;
            clip_count <= '0;
        end else begin
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                act_shape  <= q_shape[rd_ptr];
                act_radius <= q_radius[rd_ptr];
                act_cx     <= q_cx[rd_ptr];
                act_cy     <= q_cy[rd_ptr];
                state      <= LAUNCH;
            end else if (state == LAUNCH) begin
                state <= RUN;
            end else if (sel_done) begin
                state <= IDLE;
            end
            // a pixel arriving with done is still forwarded
            _valid   <= pix && in_bounds;
            cmd_done <= sel_done;
            if (pix && in_bounds) begin
                _out0  <= px;
                _out1  <= py;
                _shape <= act_shape;
            end
            if (pix && !in_bounds && clip_count != 16'hFFFF) clip_count <= clip_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: drives a stub generator per command and checks start
// pulses, offset/clipped pixels and completion against a command-queue model.
module tb_draw_scheduler;
    localparam int WIDTH = 64, HEIGHT = 64, DEPTH = 4;
    typedef struct { bit shape; int radius; int cx; int cy; } cmd_t;
    typedef struct { logic [1:0] st; logic signed [31:0] r0; logic signed [31:0] r1; int cyc; } start_t;
    logic _clock = 1'b0, _reset_n = 1'b0;
    logic cmd_valid, cmd_ready, cmd_shape;
    logic signed [31:0] cmd_radius, cmd_cx, cmd_cy;
    logic gen0_start, gen0_valid, gen0_done, gen1_start, gen1_valid, gen1_done;
    logic signed [31:0] gen0_radius, gen0_out0, gen0_out1, gen1_radius, gen1_out0, gen1_out1;
    logic _valid, _shape, cmd_done, busy;
    logic signed [31:0] _out0, _out1;
    logic [15:0] clip_count;
    int checks = 0, failures = 0, cyc = 0, exp_clip = 0;
    int last_push_cyc, last_start_cyc, last_done_cyc;
    cmd_t cmd_q[$];
    start_t start_log[$];
    int px_q[$], py_q[$];

    draw_scheduler #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH)) dut (
        ._clock(_clock), ._reset_n(_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_shape(cmd_shape),
        .cmd_radius(cmd_radius), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy),
        .gen0_start(gen0_start), .gen0_radius(gen0_radius), .gen0_valid(gen0_valid),
        .gen0_done(gen0_done), .gen0_out0(gen0_out0), .gen0_out1(gen0_out1),
        .gen1_start(gen1_start), .gen1_radius(gen1_radius), .gen1_valid(gen1_valid),
        .gen1_done(gen1_done), .gen1_out0(gen1_out0), .gen1_out1(gen1_out1),
        ._valid(_valid), ._out0(_out0), ._out1(_out1), ._shape(_shape),
        .cmd_done(cmd_done), .busy(busy), .clip_count(clip_count)
    );

    always #5 _clock = ~_clock;
    always @(posedge _clock) cyc <= cyc + 1;
    // every start pulse is logged with the cycle it appeared in
    always @(negedge _clock)
        if (gen0_start || gen1_start)
            start_log.push_back('{st: {gen1_start, gen0_start}, r0: gen0_radius, r1: gen1_radius, cyc: cyc});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.shape  = 1'($urandom);
        c.radius = int'($urandom);
        c.cx     = int'($urandom_range(80)) - 10;
        c.cy     = int'($urandom_range(80)) - 10;
        return c;
    endfunction

    task automatic fill_px(input int n);
        for (int i = 0; i < n; i++) begin
            px_q.push_back(int'($urandom_range(40)) - 20);
            py_q.push_back(int'($urandom_range(40)) - 20);
        end
    endtask

    task automatic quiet_gens();
        gen0_valid = 0; gen0_done = 0; gen0_out0 = 0; gen0_out1 = 0;
        gen1_valid = 0; gen1_done = 0; gen1_out0 = 0; gen1_out1 = 0;
    endtask

    // drives the selected generator, fills the other one with noise
    task automatic drive_gen(input bit sh, input bit v, input bit d, input int x, input int y);
        if (sh) begin
            gen1_valid = v; gen1_done = d; gen1_out0 = x; gen1_out1 = y;
            gen0_valid = 1'($urandom); gen0_done = 1'($urandom);
            gen0_out0 = 32'($urandom_range(40)); gen0_out1 = 32'($urandom_range(40));
        end else begin
            gen0_valid = v; gen0_done = d; gen0_out0 = x; gen0_out1 = y;
            gen1_valid = 1'($urandom); gen1_done = 1'($urandom);
            gen1_out0 = 32'($urandom_range(40)); gen1_out1 = 32'($urandom_range(40));
        end
    endtask

    task automatic push_cmd(input cmd_t c);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL push_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        cmd_valid = 1; cmd_shape = c.shape; cmd_radius = c.radius; cmd_cx = c.cx; cmd_cy = c.cy;
        last_push_cyc = cyc;
        @(posedge _clock); #1;
        cmd_valid = 0;
        cmd_q.push_back(c);
    endtask

    // waits for the next launch, feeds px_q/py_q to the generator, then completes
    task automatic run_cmd(input bit done_last);
        cmd_t c;
        start_t s;
        int t, x, y;
        bit in_b, last, exp_done;
        t = 0;
        while (start_log.size() == 0 && t < 100) begin
            @(negedge _clock);
            t++;
        end
        checks++;
        if (start_log.size() == 0 || cmd_q.size() == 0) begin
            failures++;
            $display("FAIL start_wait: no start pulse after %0d cycles (queued=%0d)", t, cmd_q.size());
            quiet_gens();
            px_q.delete(); py_q.delete();
            return;
        end
        s = start_log.pop_front();
        c = cmd_q.pop_front();
        last_start_cyc = s.cyc;
        if (s.st !== (c.shape ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL start_sel: starts {g1,g0}=%b, required %b", s.st, c.shape ? 2'b10 : 2'b01);
        end
        checks++;
        if ((c.shape ? s.r1 : s.r0) !== c.radius) begin
            failures++;
            $display("FAIL start_radius: %0d, required %0d", c.shape ? s.r1 : s.r0, c.radius);
        end
        while (cyc <= s.cyc) begin
            @(posedge _clock); #1;
        end
        drive_gen(c.shape, 0, 0, 0, 0);
        for (int i = 0; i < px_q.size(); i++) begin
            last = i == px_q.size() - 1;
            exp_done = last && done_last;
            x = c.cx + px_q[i];
            y = c.cy + py_q[i];
            in_b = x >= 0 && x < WIDTH && y >= 0 && y < HEIGHT;
            if (!in_b && exp_clip < 65535) exp_clip++;
            drive_gen(c.shape, 1, exp_done, px_q[i], py_q[i]);
            @(posedge _clock); #1;
            drive_gen(c.shape, 0, 0, 0, 0);
            @(negedge _clock);
            checks++;
            if (_valid !== in_b) begin
                failures++;
                $display("FAIL pix_valid: (%0d,%0d) _valid=%b, required %b", x, y, _valid, in_b);
            end
            if (in_b) begin
                checks++;
                if (_out0 !== x || _out1 !== y || _shape !== c.shape) begin
                    failures++;
                    $display("FAIL pix_data: (%0d,%0d,%b), required (%0d,%0d,%b)", _out0, _out1, _shape, x, y, c.shape);
                end
            end
            checks++;
            if (cmd_done !== exp_done) begin
                failures++;
                $display("FAIL pix_done: cmd_done=%b, required %b", cmd_done, exp_done);
            end
            checks++;
            if (clip_count !== 16'(exp_clip)) begin
                failures++;
                $display("FAIL clip_count: %0d, required %0d", clip_count, exp_clip);
            end
            if (!last && $urandom_range(3) == 0) begin
                @(negedge _clock);
                checks++;
                if (_valid !== 1'b0 || cmd_done !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_idle: _valid=%b cmd_done=%b, required 0 0", _valid, cmd_done);
                end
            end
        end
        if (!done_last || px_q.size() == 0) begin
            drive_gen(c.shape, 0, 1, 0, 0);
            @(posedge _clock); #1;
            drive_gen(c.shape, 0, 0, 0, 0);
            @(negedge _clock);
            checks++;
            if (cmd_done !== 1'b1 || _valid !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse: cmd_done=%b _valid=%b, required 1 0", cmd_done, _valid);
            end
        end
        last_done_cyc = cyc;
        checks++;
        if ((c.shape ? gen1_radius : gen0_radius) !== c.radius || start_log.size() != 0) begin
            failures++;
            $display("FAIL radius_hold: radius=%0d extra_starts=%0d, required %0d 0",
                     c.shape ? gen1_radius : gen0_radius, start_log.size(), c.radius);
        end
        quiet_gens();
        px_q.delete(); py_q.delete();
    endtask

    task automatic test_reset();
        _reset_n = 0;
        cmd_valid = 1; cmd_shape = 1; cmd_radius = 7; cmd_cx = 3; cmd_cy = 3;
        gen0_valid = 1; gen0_done = 1; gen0_out0 = 4; gen0_out1 = 4;
        gen1_valid = 1; gen1_done = 1; gen1_out0 = 5; gen1_out1 = 5;
        repeat (2) @(posedge _clock);
        #1;
        start_log.delete();
        checks++;
        if ({gen0_start, gen1_start, _valid, _shape, cmd_done, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: {g0s,g1s,valid,shape,done,busy}=%b, required 000000",
                     {gen0_start, gen1_start, _valid, _shape, cmd_done, busy});
        end
        checks++;
        if (gen0_radius !== 0 || gen1_radius !== 0 || _out0 !== 0 || _out1 !== 0) begin
            failures++;
            $display("FAIL reset_data: r0=%0d r1=%0d x=%0d y=%0d, required all 0", gen0_radius, gen1_radius, _out0, _out1);
        end
        checks++;
        if (cmd_ready !== 1'b1 || clip_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_ready: cmd_ready=%b clip=%0d, required 1 0", cmd_ready, clip_count);
        end
        _reset_n = 1;
        cmd_valid = 0;
        quiet_gens();
        repeat (3) @(negedge _clock);
        checks++;
        if (busy !== 1'b0 || start_log.size() != 0) begin
            failures++;
            $display("FAIL reset_no_push: busy=%b starts=%0d, required 0 0", busy, start_log.size());
        end
    endtask

    task automatic test_single();
        push_cmd('{shape: 1'b1, radius: 5, cx: 10, cy: 10});
        px_q = '{-2, 0};
        py_q = '{3, 0};
        run_cmd(0);
        checks++;
        if (last_start_cyc != last_push_cyc + 2) begin
            failures++;
            $display("FAIL start_latency: start %0d cycles after push, required 2", last_start_cyc - last_push_cyc);
        end
        @(negedge _clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_clip();
        push_cmd('{shape: 1'($urandom), radius: 3, cx: 0, cy: 0});
        px_q = '{-1, 63, 64};
        py_q = '{0, 63, 0};
        run_cmd(1);
        checks++;
        if (clip_count !== 16'd2) begin
            failures++;
            $display("FAIL clip_total: %0d, required 2", clip_count);
        end
        push_cmd('{shape: 1'($urandom), radius: 1, cx: 32'h7FFFFFFF, cy: 5});
        px_q = '{1, -2147483644};
        py_q = '{0, 0};
        run_cmd(0);
        checks++;
        if (clip_count !== 16'd3) begin
            failures++;
            $display("FAIL clip_wrap: %0d, required 3", clip_count);
        end
    endtask

    task automatic test_stale_done();
        cmd_t c;
        for (int k = 0; k < 2; k++) begin
            c = rand_cmd();
            c.shape = 1'(k);
            if (c.shape) gen1_done = 1; else gen0_done = 1;
            push_cmd(c);
            fill_px(2);
            run_cmd(0);
        end
    endtask

    task automatic test_back_to_back();
        int d;
        push_cmd(rand_cmd());
        push_cmd(rand_cmd());
        fill_px($urandom_range(1, 3));
        run_cmd(1'($urandom));
        d = last_done_cyc;
        fill_px($urandom_range(0, 3));
        run_cmd(1'($urandom));
        checks++;
        if (last_start_cyc != d + 1) begin
            failures++;
            $display("FAIL back_to_back: start %0d cycles after cmd_done, required 1", last_start_cyc - d);
        end
    endtask

    task automatic test_queue_full();
        cmd_t c;
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd();
            c.shape = 1'(i);
            push_cmd(c);
        end
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL queue_full: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
        end
        for (int i = 0; i < 5; i++) begin
            fill_px($urandom_range(1, 3));
            run_cmd(1'($urandom));
        end
    endtask

    task automatic test_reset_mid_run();
        cmd_t a;
        a = rand_cmd();
        push_cmd(a);
        repeat (2) @(posedge _clock);
        #1;
        checks++;
        if (start_log.size() != 1) begin
            failures++;
            $display("FAIL mid_start: %0d starts logged, required 1", start_log.size());
        end
        drive_gen(a.shape, 1, 0, 20 - a.cx, 20 - a.cy);
        push_cmd(rand_cmd());
        drive_gen(a.shape, 0, 0, 0, 0);
        push_cmd(rand_cmd());
        _reset_n = 0;
        cmd_valid = 1; cmd_shape = 0; cmd_radius = 9; cmd_cx = 1; cmd_cy = 1;
        drive_gen(a.shape, 1, 1, 20 - a.cx, 20 - a.cy);
        @(posedge _clock); #1;
        _reset_n = 1;
        cmd_valid = 0;
        cmd_q.delete();
        start_log.delete();
        exp_clip = 0;
        @(negedge _clock);
        checks++;
        if (cmd_done !== 1'b0 || _valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || clip_count !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: done=%b valid=%b ready=%b busy=%b clip=%0d, required 0 0 1 0 0",
                     cmd_done, _valid, cmd_ready, busy, clip_count);
        end
        repeat (3) begin
            @(negedge _clock);
            checks++;
            if (cmd_done !== 1'b0 || _valid !== 1'b0 || busy !== 1'b0 || start_log.size() != 0) begin
                failures++;
                $display("FAIL mid_abandon: done=%b valid=%b busy=%b starts=%0d, required 0 0 0 0",
                         cmd_done, _valid, busy, start_log.size());
            end
        end
        quiet_gens();
        push_cmd(rand_cmd());
        fill_px($urandom_range(1, 3));
        run_cmd(1);
    endtask

    task automatic test_random();
        int n;
        repeat (6) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push_cmd(rand_cmd());
            for (int i = 0; i < n; i++) begin
                fill_px($urandom_range(0, 5));
                run_cmd(1'($urandom));
            end
        end
    endtask

    initial begin
        cmd_valid = 0; cmd_shape = 0; cmd_radius = 0; cmd_cx = 0; cmd_cy = 0;
        quiet_gens();
        test_reset();
        test_single();
        test_clip();
        test_stale_done();
        test_back_to_back();
        test_queue_full();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
